load_store_unit: RTL

//  Memory-side executor for load/store instructions. It takes one decoded LB/LH/LW/LBU/LHU/SB/SH/SW

---
 rtl/load_store_unit.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store executor: accepts one decoded RV32I load/store, checks alignment,
// runs a single req/ack transaction on the data bus with lane steering, and
// returns extended load data or an error (misaligned / bus timeout).
//
// Handshakes:
//   Core side: a request is accepted on a rising edge where req_valid_i and
//   req_ready_o are both 1. req_ready_o is 1 only in IDLE. The result comes back
//   as a one-cycle rsp_valid_o pulse; rsp_* payload is 0 whenever rsp_valid_o=0.
//   Bus side: bus_req_o is held with stable addr/we/be/wdata until a rising edge
//   where bus_ack_i=1 (transaction done, bus_rdata_i captured for reads) or until
//   ACK_TIMEOUT cycles pass without ack (transaction abandoned). bus_ack_i is
//   ignored whenever the unit is not in BUS.
module load_store_unit #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_misaligned_o,
  output logic        rsp_timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;

  // Request fields needed after acceptance to shape the load result.
  logic        lat_we, nxt_lat_we;
  logic [2:0]  lat_funct3, nxt_lat_funct3;
  logic [1:0]  lat_addr_lo, nxt_lat_addr_lo;

  // Next values of the registered outputs.
  logic        nxt_req_ready;
  logic        nxt_rsp_valid;
  logic [31:0] nxt_rsp_rdata;
  logic        nxt_rsp_misaligned;
  logic        nxt_rsp_timeout;
  logic        nxt_bus_req;
  logic        nxt_bus_we;
  logic [31:0] nxt_bus_addr;
  logic [3:0]  nxt_bus_be;
  logic [31:0] nxt_bus_wdata;

  // Lane-steered store data / enables and the alignment verdict for the
  // request currently on the core port.
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        req_err;
  logic [31:0] ld_data;

  assign dbg_state_o = state;

  // True when the funct3/address pair cannot be executed as one aligned access.
  function automatic logic access_error(input logic we, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic err;
    err = 1'b0;
    if (we) begin
      if (f3 > 3'd2) err = 1'b1;
    end else begin
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) err = 1'b1;
    end
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) err = 1'b1;
    if (f3 == 3'd2 && a != 2'b00) err = 1'b1;
    return err;
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'h0, b};
      3'd5:    r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Byte-lane steering of the incoming store; reads enable all lanes.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = 32'h0;
    if (req_we_i) begin
      case (req_funct3_i[1:0])
        2'd0: begin
          st_wdata = {4{req_wdata_i[7:0]}};
          st_be    = 4'b0001 << req_addr_i[1:0];
        end
        2'd1: begin
          st_wdata = {2{req_wdata_i[15:0]}};
          st_be    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = req_wdata_i;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  assign req_err = access_error(req_we_i, req_funct3_i, req_addr_i[1:0]);
  assign ld_data = load_extract(lat_funct3, lat_addr_lo, bus_rdata_i);

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    nxt_state          = state;
    nxt_cnt            = cnt;
    nxt_lat_we         = lat_we;
    nxt_lat_funct3     = lat_funct3;
    nxt_lat_addr_lo    = lat_addr_lo;
    nxt_req_ready      = req_ready_o;
    nxt_rsp_valid      = rsp_valid_o;
    nxt_rsp_rdata      = rsp_rdata_o;
    nxt_rsp_misaligned = rsp_misaligned_o;
    nxt_rsp_timeout    = rsp_timeout_o;
    nxt_bus_req        = bus_req_o;
    nxt_bus_we         = bus_we_o;
    nxt_bus_addr       = bus_addr_o;
    nxt_bus_be         = bus_be_o;
    nxt_bus_wdata      = bus_wdata_o;

    case (state)
      S_IDLE: begin
        nxt_req_ready = 1'b1;
        if (req_valid_i) begin
          nxt_lat_we      = req_we_i;
          nxt_lat_funct3  = req_funct3_i;
          nxt_lat_addr_lo = req_addr_i[1:0];
          nxt_req_ready   = 1'b0;
          nxt_cnt         = '0;
          if (req_err) begin
            // Rejected without touching the bus; answer in the next cycle.
            nxt_state          = S_RESP;
            nxt_rsp_valid      = 1'b1;
            nxt_rsp_misaligned = 1'b1;
            nxt_rsp_timeout    = 1'b0;
            nxt_rsp_rdata      = 32'h0;
          end else begin
            nxt_state     = S_BUS;
            nxt_bus_req   = 1'b1;
            nxt_bus_we    = req_we_i;
            nxt_bus_addr  = {req_addr_i[31:2], 2'b00};
            nxt_bus_be    = st_be;
            nxt_bus_wdata = st_wdata;
          end
        end
      end

      S_BUS: begin
        if (bus_ack_i) begin
          nxt_state          = S_RESP;
          nxt_bus_req        = 1'b0;
          nxt_bus_we         = 1'b0;
          nxt_bus_addr       = 32'h0;
          nxt_bus_be         = 4'h0;
          nxt_bus_wdata      = 32'h0;
          nxt_rsp_valid      = 1'b1;
          nxt_rsp_misaligned = 1'b0;
          nxt_rsp_timeout    = 1'b0;
          nxt_rsp_rdata      = lat_we ? 32'h0 : ld_data;
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          // Last permitted wait cycle passed without ack: abandon the access.
          nxt_state          = S_RESP;
          nxt_bus_req        = 1'b0;
          nxt_bus_we         = 1'b0;
          nxt_bus_addr       = 32'h0;
          nxt_bus_be         = 4'h0;
          nxt_bus_wdata      = 32'h0;
          nxt_rsp_valid      = 1'b1;
          nxt_rsp_misaligned = 1'b0;
          nxt_rsp_timeout    = 1'b1;
          nxt_rsp_rdata      = 32'h0;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      S_RESP: begin
        nxt_state          = S_IDLE;
        nxt_rsp_valid      = 1'b0;
        nxt_rsp_misaligned = 1'b0;
        nxt_rsp_timeout    = 1'b0;
        nxt_rsp_rdata      = 32'h0;
        nxt_req_ready      = 1'b1;
      end

      default: begin
        nxt_state     = S_IDLE;
        nxt_req_ready = 1'b1;
      end
    endcase
  end

  // State, latched request fields and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= S_IDLE;
      cnt              <= '0;
      lat_we           <= 1'b0;
      lat_funct3       <= 3'h0;
      lat_addr_lo      <= 2'h0;
      req_ready_o      <= 1'b1;
      rsp_valid_o      <= 1'b0;
      rsp_rdata_o      <= 32'h0;
      rsp_misaligned_o <= 1'b0;
      rsp_timeout_o    <= 1'b0;
      bus_req_o        <= 1'b0;
      bus_we_o         <= 1'b0;
      bus_addr_o       <= 32'h0;
      bus_be_o         <= 4'h0;
      bus_wdata_o      <= 32'h0;
    end else begin
      state            <= nxt_state;
      cnt              <= nxt_cnt;
      lat_we           <= nxt_lat_we;
      lat_funct3       <= nxt_lat_funct3;
      lat_addr_lo      <= nxt_lat_addr_lo;
      req_ready_o      <= nxt_req_ready;
      rsp_valid_o      <= nxt_rsp_valid;
      rsp_rdata_o      <= nxt_rsp_rdata;
      rsp_misaligned_o <= nxt_rsp_misaligned;
      rsp_timeout_o    <= nxt_rsp_timeout;
      bus_req_o        <= nxt_bus_req;
      bus_we_o         <= nxt_bus_we;
      bus_addr_o       <= nxt_bus_addr;
      bus_be_o         <= nxt_bus_be;
      bus_wdata_o      <= nxt_bus_wdata;
    end
  end

endmodule
